// File: rtl/serializer_seq_if.sv
// Mode, control and strobe signals between the CRT sequencer and the pixel serializer.
// master drives the mode/control inputs; slave is the serializer itself.
interface serializer_seq_if;
   logic       dclk_div2;
   logic       c_9dot;
   logic       text_n;
   logic       g_gr05_b6;
   logic       line_start;
   logic       disp_en;
   logic       fifo_empty;
   logic       clr_underrun;
   logic       c_dclk_en;
   logic       c_shift_clk;
   logic       c_shift_ld;
   logic       pre_load;
   logic       fifo_rd;
   logic       underrun;
   logic [3:0] dot_cnt;

   modport master (
      output dclk_div2, c_9dot, text_n, g_gr05_b6, line_start, disp_en, fifo_empty, clr_underrun,
      input  c_dclk_en, c_shift_clk, c_shift_ld, pre_load, fifo_rd, underrun, dot_cnt
   );

   modport slave (
      input  dclk_div2, c_9dot, text_n, g_gr05_b6, line_start, disp_en, fifo_empty, clr_underrun,
      output c_dclk_en, c_shift_clk, c_shift_ld, pre_load, fifo_rd, underrun, dot_cnt
   );
endinterface

// File: rtl/serializer_seq.sv
// Character/dot timing for the CRT pixel serializer: dot counter, shift/load strobes,
// FIFO read request one dot ahead of each load, and FIFO underrun detection.
module serializer_seq #(
   parameter int UNDERRUN_STICKY = 1
) (
   input logic              t_crt_clk,
   input logic              h_reset,
   serializer_seq_if.slave  bus
);

   logic [3:0] r_dotCnt;
   logic       r_phase;
   logic       r_underrun;

   logic       w_en;
   logic       w_mode256;
   logic [3:0] w_dotLast;
   logic       w_active;
   logic       w_preLoad;
   logic       w_underrunEvent;

   // Half-rate dot clock enables every other cycle; full rate enables every cycle.
   assign w_en      = ~bus.dclk_div2 | r_phase;
   assign w_mode256 = bus.g_gr05_b6 & bus.text_n;
   assign w_dotLast = (bus.c_9dot & ~bus.text_n) ? 4'd8 : 4'd7;

   // Strobes are silenced during reset and on the realignment cycle.
   assign w_active        = ~h_reset & ~bus.line_start;
   assign w_preLoad       = w_active & w_en & (r_dotCnt == w_dotLast);
   assign w_underrunEvent = w_preLoad & bus.disp_en & bus.fifo_empty;

   assign bus.c_dclk_en   = w_active & w_en;
   assign bus.c_shift_ld  = w_active & w_en & (r_dotCnt == 4'd0);
   assign bus.c_shift_clk = w_active & w_en & (r_dotCnt != 4'd8) & (~w_mode256 | ~r_dotCnt[0]);
   assign bus.pre_load    = w_preLoad;
   assign bus.fifo_rd     = w_preLoad & bus.disp_en & ~bus.fifo_empty;
   assign bus.underrun    = r_underrun;
   assign bus.dot_cnt     = r_dotCnt;

   // Dot counter and dot-clock phase; ">=" lets a 9-dot to 8-dot switch at dot 8 wrap cleanly.
   always_ff @(posedge t_crt_clk) begin
      if (h_reset) begin
         r_dotCnt <= 4'd0;
         r_phase  <= 1'b0;
      end else if (bus.line_start) begin
         r_dotCnt <= 4'd0;
         r_phase  <= 1'b0;
      end else begin
         r_phase <= bus.dclk_div2 ? ~r_phase : 1'b0;
         if (w_en) begin
            if (r_dotCnt >= w_dotLast) begin
               r_dotCnt <= 4'd0;
            end else begin
               r_dotCnt <= r_dotCnt + 4'd1;
            end
         end
      end
   end

   // Underrun flag: sticky until cleared (set wins over clear), or a one-cycle pulse.
   always_ff @(posedge t_crt_clk) begin
      if (h_reset) begin
         r_underrun <= 1'b0;
      end else if (UNDERRUN_STICKY != 0) begin
         if (w_underrunEvent) begin
            r_underrun <= 1'b1;
         end else if (bus.clr_underrun) begin
            r_underrun <= 1'b0;
         end
      end else begin
         r_underrun <= w_underrunEvent;
      end
   end

endmodule
